// File: rtl/event_encoder_8to3.sv
// Event encoder: sticky 8-line pending vector served as 3-bit codes over valid/ready.
// Define ROUND_ROBIN_EN for rotating selection; otherwise the lowest pending index wins.
module event_encoder_8to3 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [2:0] out_code,
    output logic [3:0] pend_cnt,
    output logic       overflow
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    state_t     state_r;
    logic [7:0] pending_r;
    logic       out_valid_r;
    logic [2:0] out_code_r;
    logic [3:0] pend_cnt_r;
    logic       overflow_r;

    logic       fire_s;
    logic       ovf_hit_s;
    logic [7:0] clr_s;
    logic [7:0] pending_nx_s;
    logic [2:0] sel_code_s;
`ifdef ROUND_ROBIN_EN
    logic [2:0] rr_ptr_r;
    logic [2:0] search_base_s;
`endif

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'h01 << idx;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] vec);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'd0, vec[i]};
        end
        return cnt;
    endfunction

    // First set bit found searching upward from base, wrapping 7->0.
    function automatic logic [2:0] sel_from(input logic [7:0] vec, input logic [2:0] base);
        logic [2:0] idx;
        logic [2:0] result;
        logic       found;
        result = 3'd0;
        found  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = base + i[2:0];
            if (!found && vec[idx]) begin
                result = idx;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    // Handshake, pending next-state and selection of the next code.
    always_comb begin
        fire_s       = out_valid_r & out_ready;
        clr_s        = fire_s ? onehot8(out_code_r) : 8'h00;
        pending_nx_s = (pending_r & ~clr_s) | req;
        ovf_hit_s    = |(req & pending_r & ~clr_s);
`ifdef ROUND_ROBIN_EN
        // A grant in this cycle moves the search start past the accepted line.
        search_base_s = fire_s ? (out_code_r + 3'd1) : rr_ptr_r;
        sel_code_s    = sel_from(pending_nx_s, search_base_s);
`else
        sel_code_s    = sel_from(pending_nx_s, 3'd0);
`endif
    end

    // Pending vector, counters, sticky overflow and the presenting state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            pending_r   <= 8'h00;
            out_valid_r <= 1'b0;
            out_code_r  <= 3'd0;
            pend_cnt_r  <= 4'd0;
            overflow_r  <= 1'b0;
`ifdef ROUND_ROBIN_EN
            rr_ptr_r    <= 3'd0;
`endif
        end else begin
            pending_r  <= pending_nx_s;
            pend_cnt_r <= popcount8(pending_nx_s);
            if (ovf_hit_s) begin
                overflow_r <= 1'b1;
            end
`ifdef ROUND_ROBIN_EN
            if (fire_s) begin
                rr_ptr_r <= out_code_r + 3'd1;
            end
`endif
            // out_code only changes on a load that has something to present.
            case (state_r)
                ST_IDLE: begin
                    if (|pending_nx_s) begin
                        state_r     <= ST_PRESENT;
                        out_valid_r <= 1'b1;
                        out_code_r  <= sel_code_s;
                    end
                end
                ST_PRESENT: begin
                    if (fire_s) begin
                        if (|pending_nx_s) begin
                            out_code_r <= sel_code_s;
                        end else begin
                            state_r     <= ST_IDLE;
                            out_valid_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_r;
    assign out_code  = out_code_r;
    assign pend_cnt  = pend_cnt_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_event_encoder_8to3.sv
// Self-checking bench for event_encoder_8to3: expected codes are queued when events
// are driven and popped by a monitor whenever the encoder hands a code over.
module tb_event_encoder_8to3;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_code;
    logic [3:0] pend_cnt;
    logic       overflow;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] exp_q[$];
    logic [2:0] mon_exp;

    event_encoder_8to3 dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .pend_cnt  (pend_cnt),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Scoreboard: every accepted code must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_code got %0d expected none", out_code);
            end else begin
                mon_exp = exp_q.pop_front();
                if (out_code !== mon_exp) begin
                    errors++;
                    $display("FAIL code got %0d expected %0d", out_code, mon_exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        rst = 1'b1; req = 8'hFF; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, out_code, pend_cnt, overflow} !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b expected 0", {out_valid, out_code, pend_cnt, overflow});
        end
        @(posedge clk); #1;
        rst = 1'b0; req = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || pend_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset_release got valid=%0d cnt=%0d expected 0 0", out_valid, pend_cnt);
        end
    endtask

    task automatic test_single();
        rst = 1'b1; req = 8'h00; out_ready = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        exp_q.push_back(3'd5);
        req = 8'h20;
        @(posedge clk); #1;
        req = 8'h00;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || pend_cnt !== 4'd1) begin
            errors++;
            $display("FAIL single_latency got valid=%0d cnt=%0d expected 1 1", out_valid, pend_cnt);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || pend_cnt !== 4'd0) begin
            errors++;
            $display("FAIL single_idle got valid=%0d cnt=%0d expected 0 0", out_valid, pend_cnt);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_drain got %0d left expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_priority();
        rst = 1'b1; req = 8'h00; out_ready = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        exp_q.push_back(3'd0); exp_q.push_back(3'd4); exp_q.push_back(3'd7);
        req = 8'h91;
        @(posedge clk); #1;
        req = 8'h00;
        for (int k = 3; k >= 0; k--) begin
            @(negedge clk);
            checks++;
            if (pend_cnt !== k[3:0]) begin
                errors++;
                $display("FAIL priority_cnt got %0d expected %0d", pend_cnt, k);
            end
        end
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL priority_drain got left=%0d valid=%0d expected 0 0", exp_q.size(), out_valid);
        end
        exp_q.delete();
    endtask

    task automatic test_stall();
        rst = 1'b1; req = 8'h00; out_ready = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        req = 8'h0C;
        @(posedge clk); #1;
        req = 8'h00;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_code !== 3'd2 || pend_cnt !== 4'd2) begin
                errors++;
                $display("FAIL stall_hold got valid=%0d code=%0d cnt=%0d expected 1 2 2",
                         out_valid, out_code, pend_cnt);
            end
        end
        exp_q.push_back(3'd2); exp_q.push_back(3'd3);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain got left=%0d valid=%0d expected 0 0", exp_q.size(), out_valid);
        end
        exp_q.delete();
    endtask

    task automatic test_reissue();
        rst = 1'b1; req = 8'h00; out_ready = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        req = 8'h08;
        @(posedge clk); #1;
        exp_q.push_back(3'd3); exp_q.push_back(3'd3);
        out_ready = 1'b1;
        req = 8'h08;
        @(posedge clk); #1;
        out_ready = 1'b0; req = 8'h00;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_code !== 3'd3 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reissue got valid=%0d code=%0d ovf=%0d expected 1 3 0",
                     out_valid, out_code, overflow);
        end
        @(posedge clk); #1;
        req = 8'h08;
        @(posedge clk); #1;
        req = 8'h00;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set got %0d expected 1", overflow);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        checks++;
        if (overflow !== 1'b1 || out_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL overflow_sticky got ovf=%0d valid=%0d left=%0d expected 1 0 0",
                     overflow, out_valid, exp_q.size());
        end
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear got %0d expected 0", overflow);
        end
    endtask

    task automatic test_back_to_back();
        rst = 1'b1; req = 8'h00; out_ready = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
`ifdef ROUND_ROBIN_EN
        for (int k = 0; k < 8; k++) exp_q.push_back(k[2:0]);
        for (int k = 0; k < 7; k++) exp_q.push_back(k[2:0]);
`else
        for (int k = 0; k < 8; k++) exp_q.push_back(3'd0);
        for (int k = 1; k < 8; k++) exp_q.push_back(k[2:0]);
`endif
        req = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (pend_cnt !== 4'd8 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_cnt got cnt=%0d valid=%0d expected 8 1", pend_cnt, out_valid);
        end
        repeat (5) @(posedge clk); #1;
        req = 8'h00;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || out_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL b2b_drain got left=%0d valid=%0d ovf=%0d expected 0 0 1",
                     exp_q.size(), out_valid, overflow);
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_stall();
        test_reissue();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
